// File: rtl/button_panel_pkg.sv
// Shared types and sizing helpers for the button panel.
package button_panel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BEEP = 1'b1
  } beep_state_t;

  // A counter that must reach value needs $clog2(value+1) bits.
  function automatic int cnt_width(input int value);
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser, counter debouncer, rising-edge strobe.
module button_debounce
  import button_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic rise_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic          stable_prev_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q        <= 1'b0;
      sync_q        <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      rise_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      meta_q        <= btn_raw;
      sync_q        <= meta_q;
      stable_prev_q <= stable_q;
      rise_q        <= stable_q & ~stable_prev_q;
      // Any agreement with the accepted level restarts the count.
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable     = stable_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/button_panel.sv
// Front-panel block: N debounced buttons, momentary/toggle LEDs, retriggerable beeper.
module button_panel
  import button_panel_pkg::*;
#(
  parameter int               N_BTN            = 5,
  parameter int               DEBOUNCE_CYCLES  = 50000,
  parameter logic [N_BTN-1:0] MODE_MASK        = '0,
  parameter int               TONE_HALF_PERIOD = 32768,
  parameter int               BEEP_CYCLES      = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] led,
  output logic [N_BTN-1:0] press_pulse,
  output logic             buzzer
);

  localparam int TW = cnt_width(BEEP_CYCLES);
  localparam int HW = cnt_width(TONE_HALF_PERIOD);
  localparam logic [TW-1:0] BEEP_LAST = TW'(BEEP_CYCLES - 1);
  localparam logic [HW-1:0] TONE_LAST = HW'(TONE_HALF_PERIOD - 1);

  logic [N_BTN-1:0] stable_w;
  logic [N_BTN-1:0] rise_w;
  logic [N_BTN-1:0] toggle_q;
  logic             any_press;

  beep_state_t      state_q;
  logic [TW-1:0]    timer_q;
  logic [HW-1:0]    tone_q;
  logic             buzzer_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_in[i]),
      .stable    (stable_w[i]),
      .rise_pulse(rise_w[i])
    );
  end

  assign any_press   = |rise_w;
  assign press_pulse = rise_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ rise_w;
    end
  end

  // Momentary channels show the debounced level straight from its register.
  always_comb begin
    led = '0;
    for (int i = 0; i < N_BTN; i++) begin
      led[i] = MODE_MASK[i] ? toggle_q[i] : stable_w[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      tone_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_press) begin
            state_q  <= BEEP;
            timer_q  <= BEEP_LAST;
            tone_q   <= '0;
            buzzer_q <= 1'b1;
          end
        end
        BEEP: begin
          if (tone_q == TONE_LAST) begin
            tone_q   <= '0;
            buzzer_q <= ~buzzer_q;
          end else begin
            tone_q <= tone_q + 1'b1;
          end
          // A retrigger only extends the duration; the tone phase runs on.
          if (any_press) begin
            timer_q <= BEEP_LAST;
          end else if (timer_q == '0) begin
            state_q  <= IDLE;
            tone_q   <= '0;
            buzzer_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_button_panel.sv
// Directed bench for button_panel with a small fast configuration.
module tb_button_panel;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] led;
  logic [N-1:0] press_pulse;
  logic         buzzer;

  int n_tests = 0;
  int n_fail  = 0;

  button_panel #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (4),
    .MODE_MASK       (5'b00010),
    .TONE_HALF_PERIOD(2),
    .BEEP_CYCLES     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .led        (led),
    .press_pulse(press_pulse),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges; sampling point is 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic exp_buzz(input int k, input int start, input int last);
    return (k >= start) && (k <= last) && (((k - start) % 4) < 2);
  endfunction

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    step(2);
    check("reset_led", 32'(led), 32'd0);
    check("reset_pp", 32'(press_pulse), 32'd0);
    check("reset_buzz", 32'(buzzer), 32'd0);
    rst = 1'b0;
    step(3);

    // Clean press of a momentary channel, held 20 cycles.
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      check("t1_led0", 32'(led[0]), 32'((k >= 6) && (k < 26)));
      check("t1_pp", 32'(press_pulse), (k == 7) ? 32'd1 : 32'd0);
      check("t1_buzz", 32'(buzzer), 32'(exp_buzz(k, 8, 23)));
      if (k == 20) btn_in[0] = 1'b0;
    end
    step(10);

    // Bounce: 3 high, 1 low, 3 high, then low; nothing may be accepted.
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("t2_led2", 32'(led[2]), 32'd0);
      check("t2_pp", 32'(press_pulse), 32'd0);
      check("t2_buzz", 32'(buzzer), 32'd0);
      if (k == 3) btn_in[2] = 1'b0;
      if (k == 4) btn_in[2] = 1'b1;
      if (k == 7) btn_in[2] = 1'b0;
    end

    // Toggle channel: two separate presses flip the LED on then off.
    for (int p = 0; p < 2; p++) begin
      btn_in[1] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        step(1);
        check("t3_led1", 32'(led[1]), (k >= 8) ? 32'(p == 0) : 32'(p == 1));
        check("t3_pp", 32'(press_pulse), (k == 7) ? 32'd2 : 32'd0);
        if (k == 10) btn_in[1] = 1'b0;
      end
      step(30);
      check("t3_led1_rel", 32'(led[1]), 32'(p == 0));
    end

    // Simultaneous press on 3 and 4, then a retrigger from channel 0.
    btn_in[4:3] = 2'b11;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check("t4_pp", 32'(press_pulse),
            (k == 7) ? 32'h18 : ((k == 18) ? 32'h01 : 32'h00));
      check("t4_buzz", 32'(buzzer), 32'(exp_buzz(k, 8, 34)));
      if (k == 11) begin
        btn_in[4:3] = 2'b00;
        btn_in[0]   = 1'b1;
      end
    end
    btn_in[0] = 1'b0;
    step(20);

    // Reset mid-beep with the toggle LED lit.
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 10) btn_in[1] = 1'b0;
    end
    check("t5_led1_pre", 32'(led[1]), 32'd1);
    check("t5_buzz_pre", 32'(buzzer), 32'd1);
    btn_in[0] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t5_led_async", 32'(led), 32'd0);
    check("t5_pp_async", 32'(press_pulse), 32'd0);
    check("t5_buzz_async", 32'(buzzer), 32'd0);
    step(2);
    check("t5_led_inrst", 32'(led), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("t5_led", 32'(led), (k >= 6) ? 32'd1 : 32'd0);
      check("t5_pp", 32'(press_pulse), (k == 7) ? 32'd1 : 32'd0);
      check("t5_buzz", 32'(buzzer), 32'(exp_buzz(k, 8, 23)));
    end
    btn_in[0] = 1'b0;
    step(40);

    // Momentary release: LED falls 6 cycles after the drop, no pulse.
    btn_in[4] = 1'b1;
    step(6);
    check("t6_led4_on", 32'(led[4]), 32'd1);
    step(4);
    btn_in[4] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("t6_led4", 32'(led[4]), 32'(k < 6));
      check("t6_pp", 32'(press_pulse), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
